// File: rtl/alu_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_seq_if                                                                  |
// | Operand/opcode/carry-in bus to the 16-bit ALU and its result/flag return.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface alu_seq_if;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_op;
    logic        alu_cf;
    logic [15:0] alu_acc;
    logic        alu_c;
    logic        alu_z;
    logic        alu_o;

    modport master (
        output alu_a, alu_b, alu_op, alu_cf,
        input  alu_acc, alu_c, alu_z, alu_o
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_cf,
        output alu_acc, alu_c, alu_z, alu_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_seq                                                                     |
// | Multi-word ADD/SUB/CMP sequencer driving a 16-bit ALU one word at a time.   |
// | Optional CMP support: define ALU_SEQ_CMP_EN.                                |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module alu_seq #(
    parameter int WORDS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [1:0]            cmd,
    input  wire logic [16*WORDS-1:0]   opa,
    input  wire logic [16*WORDS-1:0]   opb,
    output logic                       ready,
    output logic                       done,
    output logic [16*WORDS-1:0]        result,
    output logic                       carry,
    output logic                       zero,
    output logic                       ovf,
    output logic                       err,
    alu_seq_if.master                  alu_bus
);
    localparam int c_W     = 16 * WORDS;
    localparam int c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_TOP = c_IDX_W'(WORDS - 1);

    localparam logic [7:0] c_OP_NOP = 8'h00;
    localparam logic [7:0] c_OP_ADD = 8'h01;
    localparam logic [7:0] c_OP_ADC = 8'h02;
    localparam logic [7:0] c_OP_SUB = 8'h03;
    localparam logic [7:0] c_OP_SBB = 8'h04;
`ifdef ALU_SEQ_CMP_EN
    localparam logic [7:0] c_OP_CMP = 8'h09;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic                 r_sub, w_sub_nxt;
`ifdef ALU_SEQ_CMP_EN
    logic                 r_cmp, w_cmp_nxt;
`endif
    logic                 r_rej, w_rej_nxt;
    logic                 r_zacc, w_zacc_nxt;
    logic [c_W-1:0]       r_opa, w_opa_nxt;
    logic [c_W-1:0]       r_opb, w_opb_nxt;
    logic [c_W-1:0]       r_work, w_work_nxt;
    logic [c_W-1:0]       r_result, w_result_nxt;
    logic                 r_carry, w_carry_nxt;
    logic                 r_zero, w_zero_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic [15:0]          r_alu_a, w_alu_a_nxt;
    logic [15:0]          r_alu_b, w_alu_b_nxt;
    logic [7:0]           r_alu_op, w_alu_op_nxt;
    logic                 r_alu_cf, w_alu_cf_nxt;

    logic [15:0]          w_a_cur;
    logic [15:0]          w_b_cur;
    logic                 w_r15;
    logic                 w_co;
    logic                 w_bo;
    logic                 w_chain;
    logic [c_IDX_W-1:0]   w_idx_inc;

    function automatic logic [15:0] f_word(input logic [c_W-1:0] v, input logic [c_IDX_W-1:0] i);
        return v[16*int'(i) +: 16];
    endfunction

    // The ALU's c flag is a sign-extension bit, so the unsigned inter-word
    // carry/borrow is rebuilt from the operand and result MSBs.
    assign w_a_cur   = f_word(r_opa, r_idx);
    assign w_b_cur   = f_word(r_opb, r_idx);
    assign w_r15     = alu_bus.alu_acc[15];
    assign w_co      = (w_a_cur[15] & w_b_cur[15]) | ((w_a_cur[15] | w_b_cur[15]) & ~w_r15);
    assign w_bo      = (~w_a_cur[15] & w_b_cur[15]) | ((~w_a_cur[15] | w_b_cur[15]) & w_r15);
    assign w_chain   = r_sub ? w_bo : w_co;
    assign w_idx_inc = r_idx + 1'b1;

`ifndef ALU_SEQ_CMP_EN
    logic w_unused;
    assign w_unused = alu_bus.alu_c;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_sub_nxt    = r_sub;
`ifdef ALU_SEQ_CMP_EN
        w_cmp_nxt    = r_cmp;
`endif
        w_rej_nxt    = r_rej;
        w_zacc_nxt   = r_zacc;
        w_opa_nxt    = r_opa;
        w_opb_nxt    = r_opb;
        w_work_nxt   = r_work;
        w_result_nxt = r_result;
        w_carry_nxt  = r_carry;
        w_zero_nxt   = r_zero;
        w_ovf_nxt    = r_ovf;
        w_alu_a_nxt  = r_alu_a;
        w_alu_b_nxt  = r_alu_b;
        w_alu_op_nxt = c_OP_NOP;
        w_alu_cf_nxt = r_alu_cf;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_opa_nxt  = opa;
                    w_opb_nxt  = opb;
                    w_rej_nxt  = 1'b0;
                    w_zacc_nxt = 1'b1;
                    case (cmd)
                        2'd0, 2'd1: begin
                            w_sub_nxt    = cmd[0];
`ifdef ALU_SEQ_CMP_EN
                            w_cmp_nxt    = 1'b0;
`endif
                            w_idx_nxt    = '0;
                            w_alu_a_nxt  = opa[15:0];
                            w_alu_b_nxt  = opb[15:0];
                            w_alu_op_nxt = cmd[0] ? c_OP_SUB : c_OP_ADD;
                            w_alu_cf_nxt = 1'b0;
                            w_state_nxt  = S_ISSUE;
                        end
`ifdef ALU_SEQ_CMP_EN
                        2'd2: begin
                            w_sub_nxt    = 1'b0;
                            w_cmp_nxt    = 1'b1;
                            w_idx_nxt    = c_TOP;
                            w_alu_a_nxt  = f_word(opa, c_TOP);
                            w_alu_b_nxt  = f_word(opb, c_TOP);
                            w_alu_op_nxt = c_OP_CMP;
                            w_alu_cf_nxt = 1'b0;
                            w_state_nxt  = S_ISSUE;
                        end
`endif
                        default: begin
                            w_rej_nxt   = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    endcase
                end
            end

            S_ISSUE: begin
                w_state_nxt = S_CAPTURE;
            end

            S_CAPTURE: begin
`ifdef ALU_SEQ_CMP_EN
                // CMP walks from the most significant word; first difference decides.
                if (r_cmp) begin
                    if (!alu_bus.alu_z) begin
                        w_carry_nxt = alu_bus.alu_c;
                        w_ovf_nxt   = alu_bus.alu_o;
                        w_zero_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (r_idx == '0) begin
                        w_carry_nxt = 1'b0;
                        w_ovf_nxt   = 1'b0;
                        w_zero_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt    = r_idx - 1'b1;
                        w_alu_a_nxt  = f_word(r_opa, r_idx - 1'b1);
                        w_alu_b_nxt  = f_word(r_opb, r_idx - 1'b1);
                        w_alu_op_nxt = c_OP_CMP;
                        w_alu_cf_nxt = 1'b0;
                        w_state_nxt  = S_ISSUE;
                    end
                end else
`endif
                begin
                    w_work_nxt[16*int'(r_idx) +: 16] = alu_bus.alu_acc;
                    w_zacc_nxt = r_zacc & alu_bus.alu_z;
                    if (r_idx == c_TOP) begin
                        w_result_nxt = w_work_nxt;
                        w_carry_nxt  = w_chain;
                        w_zero_nxt   = r_zacc & alu_bus.alu_z;
                        w_ovf_nxt    = alu_bus.alu_o;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_idx_nxt    = w_idx_inc;
                        w_alu_a_nxt  = f_word(r_opa, w_idx_inc);
                        w_alu_b_nxt  = f_word(r_opb, w_idx_inc);
                        w_alu_op_nxt = r_sub ? c_OP_SBB : c_OP_ADC;
                        w_alu_cf_nxt = w_chain;
                        w_state_nxt  = S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_sub    <= 1'b0;
`ifdef ALU_SEQ_CMP_EN
            r_cmp    <= 1'b0;
`endif
            r_rej    <= 1'b0;
            r_zacc   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= c_OP_NOP;
            r_alu_cf <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_sub    <= w_sub_nxt;
`ifdef ALU_SEQ_CMP_EN
            r_cmp    <= w_cmp_nxt;
`endif
            r_rej    <= w_rej_nxt;
            r_zacc   <= w_zacc_nxt;
            r_result <= w_result_nxt;
            r_carry  <= w_carry_nxt;
            r_zero   <= w_zero_nxt;
            r_ovf    <= w_ovf_nxt;
            r_alu_a  <= w_alu_a_nxt;
            r_alu_b  <= w_alu_b_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_alu_cf <= w_alu_cf_nxt;
        end
    end

    // Operand and scratch storage is always written before it is read.
    always_ff @(posedge clk) begin
        r_opa  <= w_opa_nxt;
        r_opb  <= w_opb_nxt;
        r_work <= w_work_nxt;
    end

    assign ready          = (r_state == S_IDLE);
    assign done           = (r_state == S_DONE);
    assign err            = (r_state == S_DONE) & r_rej;
    assign result         = r_result;
    assign carry          = r_carry;
    assign zero           = r_zero;
    assign ovf            = r_ovf;
    assign alu_bus.alu_a  = r_alu_a;
    assign alu_bus.alu_b  = r_alu_b;
    assign alu_bus.alu_op = r_alu_op;
    assign alu_bus.alu_cf = r_alu_cf;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alu_seq                                                                  |
// | Directed bench for alu_seq (WORDS=4) with a behavioural 16-bit ALU model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [63:0] opa = '0;
    logic [63:0] opb = '0;
    logic        ready, done, carry, zero, ovf, err;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    alu_seq_if bus ();

    alu_seq #(.WORDS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd     (cmd),
        .opa     (opa),
        .opb     (opb),
        .ready   (ready),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .ovf     (ovf),
        .err     (err),
        .alu_bus (bus)
    );

    always #5 clk = ~clk;

    // ALU model: c is bit 16 of the sign-extended sum, o is signed overflow.
    logic [16:0] m_sum;
    logic        m_cin;
    always_comb begin
        m_cin = ((bus.alu_op == 8'h02) || (bus.alu_op == 8'h04)) ? bus.alu_cf : 1'b0;
        m_sum = '0;
        if ((bus.alu_op == 8'h01) || (bus.alu_op == 8'h02))
            m_sum = {bus.alu_a[15], bus.alu_a} + {bus.alu_b[15], bus.alu_b} + {16'd0, m_cin};
        else if ((bus.alu_op == 8'h03) || (bus.alu_op == 8'h04))
            m_sum = {bus.alu_a[15], bus.alu_a} - {bus.alu_b[15], bus.alu_b} - {16'd0, m_cin};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_acc <= '0;
            bus.alu_c   <= 1'b0;
            bus.alu_z   <= 1'b0;
            bus.alu_o   <= 1'b0;
        end else if ((bus.alu_op >= 8'h01) && (bus.alu_op <= 8'h04)) begin
            bus.alu_acc <= m_sum[15:0];
            bus.alu_c   <= m_sum[16];
            bus.alu_z   <= (m_sum[15:0] == 16'd0);
            bus.alu_o   <= m_sum[16] ^ m_sum[15];
        end else if (bus.alu_op == 8'h09) begin
            bus.alu_c   <= (bus.alu_a < bus.alu_b);
            bus.alu_o   <= (bus.alu_a > bus.alu_b);
            bus.alu_z   <= (bus.alu_a == bus.alu_b);
        end
    end

    // Issues one command and observes it until done (or the cycle budget runs out).
    task automatic run_cmd(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                           output int lat, output int ops, output logic cf1,
                           output logic [63:0] res, output logic [2:0] flg,
                           output logic e, output logic after_ok);
        @(negedge clk);
        cmd = c; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; opa = ~a; opb = ~b;
        lat = 0; ops = 0; cf1 = 1'b0; res = '0; flg = '0; e = 1'b0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (bus.alu_op != 8'h00) begin
                ops++;
                if (ops == 2) cf1 = bus.alu_cf;
            end
            if (done) begin
                lat = n; res = result; flg = {carry, zero, ovf}; e = err;
            end
        end
        @(negedge clk);
        after_ok = !done && ready && !err;
    endtask

    int          lat, ops;
    logic        cf1, e, aok;
    logic [63:0] res;
    logic [2:0]  flg;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready, done, err} !== 3'b100) begin
            errors++; $display("FAIL reset_status got=%b exp=100", {ready, done, err});
        end
        checks++;
        if (result !== 64'd0) begin
            errors++; $display("FAIL reset_result got=%h exp=0", result);
        end
        checks++;
        if ({carry, zero, ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {carry, zero, ovf});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cf} !== 41'd0) begin
            errors++; $display("FAIL reset_alu_bus got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cf});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_carry();
        run_cmd(2'd0, 64'h0000_0000_0000_FFFF, 64'h1, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if (res !== 64'h0000_0000_0001_0000) begin
            errors++; $display("FAIL add_carry_result got=%h exp=0000000000010000", res);
        end
        checks++;
        if (flg !== 3'b000) begin
            errors++; $display("FAIL add_carry_flags got=%b exp=000", flg);
        end
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL add_carry_latency got=%0d exp=9", lat);
        end
        checks++;
        if (cf1 !== 1'b1) begin
            errors++; $display("FAIL add_carry_word1_cf got=%b exp=1", cf1);
        end
        checks++;
        if (ops !== 4) begin
            errors++; $display("FAIL add_carry_issue_count got=%0d exp=4", ops);
        end
        checks++;
        if (aok !== 1'b1) begin
            errors++; $display("FAIL add_carry_done_pulse got=%b exp=1", aok);
        end
    endtask

    task automatic test_add_wrap();
        run_cmd(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if (res !== 64'd0) begin
            errors++; $display("FAIL add_wrap_result got=%h exp=0", res);
        end
        checks++;
        if (flg !== 3'b110) begin
            errors++; $display("FAIL add_wrap_flags got=%b exp=110", flg);
        end
    endtask

    task automatic test_add_ovf();
        run_cmd(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if (res !== 64'h8000_0000_0000_0000) begin
            errors++; $display("FAIL add_ovf_result got=%h exp=8000000000000000", res);
        end
        checks++;
        if (flg !== 3'b001) begin
            errors++; $display("FAIL add_ovf_flags got=%b exp=001", flg);
        end
    endtask

    task automatic test_sub_borrow();
        run_cmd(2'd1, 64'h0, 64'h1, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL sub_borrow_result got=%h exp=ffffffffffffffff", res);
        end
        checks++;
        if (flg !== 3'b100) begin
            errors++; $display("FAIL sub_borrow_flags got=%b exp=100", flg);
        end
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL sub_borrow_latency got=%0d exp=9", lat);
        end
    endtask

    task automatic test_sub_ovf();
        run_cmd(2'd1, 64'h8000_0000_0000_0000, 64'h1, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if (res !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL sub_ovf_result got=%h exp=7fffffffffffffff", res);
        end
        checks++;
        if (flg !== 3'b001) begin
            errors++; $display("FAIL sub_ovf_flags got=%b exp=001", flg);
        end
    endtask

    // Expects state left by test_sub_ovf: result 7FFF.., flags 001.
    task automatic check_rejected(input logic [1:0] c, input string tag);
        run_cmd(c, 64'h1234, 64'h5678, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL %s_latency got=%0d exp=1", tag, lat);
        end
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL %s_err got=%b exp=1", tag, e);
        end
        checks++;
        if (ops !== 0) begin
            errors++; $display("FAIL %s_alu_ops got=%0d exp=0", tag, ops);
        end
        checks++;
        if ({res, flg} !== {64'h7FFF_FFFF_FFFF_FFFF, 3'b001}) begin
            errors++; $display("FAIL %s_held got=%h/%b exp=7fffffffffffffff/001", tag, res, flg);
        end
        checks++;
        if (aok !== 1'b1) begin
            errors++; $display("FAIL %s_err_pulse got=%b exp=1", tag, aok);
        end
    endtask

    task automatic test_reserved();
        check_rejected(2'd3, "reserved");
    endtask

`ifdef ALU_SEQ_CMP_EN
    task automatic test_cmp();
        run_cmd(2'd2, 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if ({flg, lat} !== {3'b001, 32'd3}) begin
            errors++; $display("FAIL cmp_gt got=%b/%0d exp=001/3", flg, lat);
        end
        checks++;
        if (res !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL cmp_result_held got=%h exp=7fffffffffffffff", res);
        end
        run_cmd(2'd2, 64'hABCD_0000_1111_2222, 64'hABCD_0000_1111_2222, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if ({flg, lat} !== {3'b010, 32'd9}) begin
            errors++; $display("FAIL cmp_eq got=%b/%0d exp=010/9", flg, lat);
        end
        run_cmd(2'd2, 64'h5, 64'h6, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if ({flg, lat} !== {3'b100, 32'd9}) begin
            errors++; $display("FAIL cmp_lt got=%b/%0d exp=100/9", flg, lat);
        end
    endtask
`else
    task automatic test_cmd2_reserved();
        check_rejected(2'd2, "cmd2_disabled");
    endtask
`endif

    task automatic test_reset_abort();
        int dn;
        @(negedge clk);
        cmd = 2'd0; opa = 64'h1; opb = 64'h1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dn = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, done, bus.alu_op} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL abort_state got=%b%b/%h exp=10/00", ready, done, bus.alu_op);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++; $display("FAIL abort_no_done got=%0d exp=0", dn);
        end
        run_cmd(2'd0, 64'h3, 64'h4, lat, ops, cf1, res, flg, e, aok);
        checks++;
        if ({res, lat} !== {64'h7, 32'd9}) begin
            errors++; $display("FAIL abort_restart got=%h/%0d exp=7/9", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_add_wrap();
        test_add_ovf();
        test_sub_borrow();
        test_sub_ovf();
        test_reserved();
`ifdef ALU_SEQ_CMP_EN
        test_cmp();
`else
        test_cmd2_reserved();
`endif
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
